// File: rtl/frac_pkg.sv
// Shared types and constants for the Mandelbrot result packer.
// Frame geometry, frame-buffer word layout and output FSM states.
package frac_pkg;

    localparam int H_RES          = 640;
    localparam int V_RES          = 480;
    localparam int PIX_PER_WORD   = 16;
    localparam int WORDS_PER_LINE = 40;
    localparam int ADDR_W         = 22;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } frac_wr_word_t;

    // Queue entry: a frame-buffer word plus an end-of-frame marker.
    typedef struct packed {
        logic          eof;
        frac_wr_word_t word;
    } frac_fifo_ent_t;

    typedef enum logic {
        IDLE,
        REQ
    } frac_out_st_e;

    // Word address of (row y, word column w); wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] frac_word_addr(
        input logic [ADDR_W-1:0] base,
        input logic [9:0]        y,
        input logic [5:0]        w
    );
        logic [ADDR_W-1:0] prod;
        prod = ADDR_W'(y) * ADDR_W'(WORDS_PER_LINE);
        return base + prod + ADDR_W'(w);
    endfunction

endpackage

// File: rtl/frac_result_packer_if.sv
// Pixel-result input, frame-buffer write port and flush/frame signals.
// FRAC_PACK_DIAG_EN adds the diagnostic counters to the bundle.
interface frac_result_packer_if;
    import frac_pkg::*;

    logic              done_tick;
    logic              found;
    logic [9:0]        px;
    logic [9:0]        py;
    logic              in_ready;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              wr_ack;
    logic              flush;
    logic              frame_done;
`ifdef FRAC_PACK_DIAG_EN
    logic [15:0]       diag_partial_cnt;
    logic [15:0]       diag_drop_cnt;
    logic              diag_err;
`endif

    // Packer side.
    modport slave (
        input  done_tick, found, px, py, wr_ack, flush,
        output in_ready, wr_req, wr_addr, wr_data, frame_done
`ifdef FRAC_PACK_DIAG_EN
        , output diag_partial_cnt, diag_drop_cnt, diag_err
`endif
    );

    // Pixel source and frame-buffer side.
    modport master (
        output done_tick, found, px, py, wr_ack, flush,
        input  in_ready, wr_req, wr_addr, wr_data, frame_done
`ifdef FRAC_PACK_DIAG_EN
        , input diag_partial_cnt, diag_drop_cnt, diag_err
`endif
    );

endinterface

// File: rtl/frac_wr_fifo.sv
// Word FIFO between the packer and the output FSM.
// Accepts up to two pushes per cycle (wd0 first); exposes head and next.
module frac_wr_fifo
    import frac_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     push_i,
    input  frac_fifo_ent_t wd0_i,
    input  frac_fifo_ent_t wd1_i,
    input  logic           pop_i,
    output frac_fifo_ent_t rd0_o,
    output frac_fifo_ent_t rd1_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [CW-1:0]  free_o,
    output logic [CW-1:0]  cnt_o
);

    frac_fifo_ent_t mem_q [DEPTH];
    logic [AW-1:0]  wptr_q;
    logic [AW-1:0]  rptr_q;
    logic [CW-1:0]  cnt_q;
    logic [AW-1:0]  wptr_nx;
    logic [AW-1:0]  rptr_nx;

    assign wptr_nx = wptr_q + AW'(1);
    assign rptr_nx = rptr_q + AW'(1);

    // Storage: entries are only read once written, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_i != 2'd0) begin
            mem_q[wptr_q] <= wd0_i;
        end
        if (push_i == 2'd2) begin
            mem_q[wptr_nx] <= wd1_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_q + AW'(push_i);
            if (pop_i) begin
                rptr_q <= rptr_nx;
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign rd0_o   = mem_q[rptr_q];
    assign rd1_o   = mem_q[rptr_nx];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign free_o  = CW'(DEPTH) - cnt_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/frac_result_packer.sv
// Packs 1-bit pixel results into 16-pixel words and issues writes.
// Optional diagnostics are built when FRAC_PACK_DIAG_EN is defined.
module frac_result_packer
    import frac_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    frac_result_packer_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [15:0]       acc_q, acc_d;
    logic [9:0]        acc_py_q, acc_py_d;
    logic [5:0]        acc_word_q, acc_word_d;
    logic              acc_vld_q, acc_vld_d;

    logic              tag_chg;
    logic              cmp;
    logic              two_push;
    logic              in_ready;
    logic              accept;
    logic              push_old;
    logic              push_new;
    logic [15:0]       acc_new;
    logic [1:0]        npush;
    frac_fifo_ent_t    old_ent, new_ent, wd0, wd1;

    frac_fifo_ent_t    rd0, rd1;
    logic              full, empty, pop;
    logic [CW-1:0]     free, cnt;

    frac_out_st_e      state_q;
    logic              wr_req_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [15:0]       wr_data_q;
    logic              eof_q;
    logic              frame_done_q;
    logic              more;
    frac_fifo_ent_t    nxt;

    // Assembly: merge the pixel, decide which words leave this cycle.
    always_comb begin
        tag_chg    = acc_vld_q &&
                     ({acc_py_q, acc_word_q} != {bus.py, bus.px[9:4]});
        cmp        = (bus.px[3:0] == 4'hF) ||
                     (bus.px == 10'(H_RES - 1));
        two_push   = bus.done_tick && tag_chg && (cmp || bus.flush);
        in_ready   = !full && !(two_push && (free < CW'(2)));
        accept     = bus.done_tick && in_ready;

        acc_new    = tag_chg ? 16'h0 : acc_q;
        acc_new[bus.px[3:0]] = bus.found;

        old_ent.eof        = 1'b0;
        old_ent.word.addr  = frac_word_addr(BASE_ADDR, acc_py_q, acc_word_q);
        old_ent.word.data  = acc_q;
        new_ent.eof        = (bus.px == 10'(H_RES - 1)) && (bus.py == 10'd0);
        new_ent.word.addr  = frac_word_addr(BASE_ADDR, bus.py, bus.px[9:4]);
        new_ent.word.data  = acc_new;

        push_old   = accept ? tag_chg
                            : (bus.flush && acc_vld_q && !full);
        push_new   = accept && (cmp || bus.flush);
        npush      = {1'b0, push_old} + {1'b0, push_new};
        wd0        = push_old ? old_ent : new_ent;
        wd1        = new_ent;

        acc_d      = acc_q;
        acc_py_d   = acc_py_q;
        acc_word_d = acc_word_q;
        acc_vld_d  = acc_vld_q;
        if (accept) begin
            acc_py_d   = bus.py;
            acc_word_d = bus.px[9:4];
            if (cmp || bus.flush) begin
                acc_d     = 16'h0;
                acc_vld_d = 1'b0;
            end else begin
                acc_d     = acc_new;
                acc_vld_d = 1'b1;
            end
        end else if (push_old) begin
            acc_d     = 16'h0;
            acc_vld_d = 1'b0;
        end
    end

    // Assembly register and tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            acc_py_q   <= '0;
            acc_word_q <= '0;
            acc_vld_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            acc_py_q   <= acc_py_d;
            acc_word_q <= acc_word_d;
            acc_vld_q  <= acc_vld_d;
        end
    end

    frac_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (npush),
        .wd0_i   (wd0),
        .wd1_i   (wd1),
        .pop_i   (pop),
        .rd0_o   (rd0),
        .rd1_o   (rd1),
        .full_o  (full),
        .empty_o (empty),
        .free_o  (free),
        .cnt_o   (cnt)
    );

    // Head leaves on ack; the next word is either queued or arriving now.
    assign pop  = (state_q == REQ) && bus.wr_ack;
    assign more = (cnt > CW'(1)) || (npush != 2'd0);
    assign nxt  = (cnt > CW'(1)) ? rd1 : wd0;

    // Output FSM: present the FIFO head until the frame buffer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            eof_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q   <= REQ;
                        wr_req_q  <= 1'b1;
                        wr_addr_q <= rd0.word.addr;
                        wr_data_q <= rd0.word.data;
                        eof_q     <= rd0.eof;
                    end
                end
                REQ: begin
                    if (bus.wr_ack) begin
                        frame_done_q <= eof_q;
                        if (more) begin
                            wr_addr_q <= nxt.word.addr;
                            wr_data_q <= nxt.word.data;
                            eof_q     <= nxt.eof;
                        end else begin
                            state_q  <= IDLE;
                            wr_req_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    wr_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.wr_req     = wr_req_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;

`ifdef FRAC_PACK_DIAG_EN
    logic [15:0] part_cnt_q;
    logic [15:0] drop_cnt_q;
    logic        diag_err_q;
    logic [1:0]  part_inc;
    logic        drop;

    assign part_inc = {1'b0, push_old} + {1'b0, push_new && !cmp};
    assign drop     = bus.done_tick && !in_ready;

    // Diagnostics: partial-word pushes, dropped ticks, sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            part_cnt_q <= '0;
            drop_cnt_q <= '0;
            diag_err_q <= 1'b0;
        end else begin
            part_cnt_q <= part_cnt_q + 16'(part_inc);
            if (drop) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
                diag_err_q <= 1'b1;
            end
        end
    end

    assign bus.diag_partial_cnt = part_cnt_q;
    assign bus.diag_drop_cnt    = drop_cnt_q;
    assign bus.diag_err         = diag_err_q;
`endif

endmodule

// File: tb/tb_frac_result_packer.sv
// Directed bench for frac_result_packer with an expected-word queue.
// Words are checked in order as the frame buffer acknowledges them.
module tb_frac_result_packer;
    import frac_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    frac_result_packer_if bus ();

    frac_result_packer #(
        .BASE_ADDR  (22'd0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int rx    = 0;
    int fd    = 0;
    frac_wr_word_t exp_q[$];
    frac_wr_word_t e;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frac_wr_word_t mk(input logic [21:0] a,
                                         input logic [15:0] d);
        frac_wr_word_t w;
        w.addr = a;
        w.data = d;
        return w;
    endfunction

    function automatic logic fpat(input int x);
        return (x % 3) == 0;
    endfunction

    // Scoreboard: every accepted request must match the next expected word.
    always @(negedge clk) begin
        if (!rst && bus.wr_req && bus.wr_ack) begin
            rx++;
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {10'd0, bus.wr_addr}, 32'hFFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {10'd0, bus.wr_addr}, {10'd0, e.addr});
                chk("wr_data", {16'd0, bus.wr_data}, {16'd0, e.data});
            end
        end
        if (!rst && bus.frame_done) fd++;
    end

    // One pixel result; waits (bounded) for in_ready. Entry/exit: posedge+1.
    task automatic tick(input logic [9:0] x, input logic [9:0] y,
                        input logic f, input logic fl);
        int n;
        n = 0;
        bus.px        = x;
        bus.py        = y;
        bus.found     = f;
        bus.done_tick = 1'b1;
        bus.flush     = fl;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            bus.done_tick = 1'b0;
            bus.flush     = 1'b0;
            @(posedge clk); #1;
            bus.done_tick = 1'b1;
            bus.flush     = fl;
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            bus.done_tick = 1'b0;
            bus.flush     = 1'b0;
            chk("tick_timeout", 32'(n), 32'd0);
        end
        @(posedge clk); #1;
        bus.done_tick = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int r0;
        int f0;
        int acc_n;
        int stall;
        logic [15:0] d;

        rst           = 1'b1;
        bus.done_tick = 1'b0;
        bus.found     = 1'b0;
        bus.px        = '0;
        bus.py        = '0;
        bus.wr_ack    = 1'b0;
        bus.flush     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_req", 32'(bus.wr_req), 32'd0);
        chk("rst_wr_addr", {10'd0, bus.wr_addr}, 32'd0);
        chk("rst_wr_data", {16'd0, bus.wr_data}, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        @(posedge clk); #1;
        rst        = 1'b0;
        bus.wr_ack = 1'b1;
        idle(1);

        // Full word at row 5, alternating pixels.
        exp_q.push_back(mk(22'd200, 16'h5555));
        r0 = rx;
        for (int i = 0; i < 16; i++) tick(10'(i), 10'd5, (i % 2) == 0, 1'b0);
        @(negedge clk);
        chk("lat_not_yet", 32'(bus.wr_req), 32'd0);
        @(negedge clk);
        chk("lat_req", 32'(bus.wr_req), 32'd1);
        repeat (3) @(negedge clk);
        chk("full_word_cnt", 32'(rx - r0), 32'd1);
        @(posedge clk); #1;

        // Whole line at row 0, ending the frame.
        for (int w = 0; w < 40; w++) exp_q.push_back(mk(22'(w), 16'hFFFF));
        r0 = rx;
        f0 = fd;
        for (int x = 0; x < 640; x++) tick(10'(x), 10'd0, 1'b1, 1'b0);
        idle(10);
        chk("line_words", 32'(rx - r0), 32'd40);
        chk("frame_done_cnt", 32'(fd - f0), 32'd1);

        // Partial word forced out by a tag change, then a flush.
        exp_q.push_back(mk(22'd80, 16'h000F));
        exp_q.push_back(mk(22'd82, 16'h0001));
        r0 = rx;
        for (int i = 0; i < 4; i++) tick(10'(i), 10'd2, 1'b1, 1'b0);
        tick(10'd32, 10'd2, 1'b1, 1'b0);
        idle(4);
        chk("tag_chg_words", 32'(rx - r0), 32'd1);
        do_flush();
        idle(4);
        chk("partial_words", 32'(rx - r0), 32'd2);
        do_flush();
        idle(4);
        chk("empty_flush", 32'(rx - r0), 32'd2);

        // Back-pressure: frame buffer stalls while 80 ticks stream in.
        for (int w = 0; w < 5; w++) begin
            d = '0;
            for (int b = 0; b < 16; b++) d[b] = fpat(16 * w + b);
            exp_q.push_back(mk(22'(400 + w), d));
        end
        r0         = rx;
        bus.wr_ack = 1'b0;
        acc_n      = 0;
        stall      = -1;
        for (int c = 0; c < 100; c++) begin
            if (acc_n < 80) begin
                bus.px        = 10'(acc_n);
                bus.py        = 10'd10;
                bus.found     = fpat(acc_n);
                bus.done_tick = 1'b1;
            end
            @(negedge clk);
            if (bus.done_tick) begin
                if (bus.in_ready) begin
                    acc_n++;
                end else begin
                    if (stall < 0) stall = acc_n;
                    bus.done_tick = 1'b0;
                end
            end
            @(posedge clk); #1;
            bus.done_tick = 1'b0;
        end
        @(negedge clk);
        chk("bp_accepted", 32'(acc_n), 32'd64);
        chk("bp_stall_at", 32'(stall), 32'd64);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_req_held", 32'(bus.wr_req), 32'd1);
        chk("bp_no_out", 32'(rx - r0), 32'd0);
`ifdef FRAC_PACK_DIAG_EN
        chk("bp_drop_cnt", 32'(bus.diag_drop_cnt), 32'd0);
        chk("bp_diag_err", 32'(bus.diag_err), 32'd0);
`endif
        @(posedge clk); #1;
        bus.wr_ack = 1'b1;
        for (int x = acc_n; x < 80; x++) tick(10'(x), 10'd10, fpat(x), 1'b0);
        idle(10);
        chk("bp_words", 32'(rx - r0), 32'd5);

        // Reset while a request is outstanding with 3 words queued.
        bus.wr_ack = 1'b0;
        for (int x = 0; x < 49; x++) tick(10'(x), 10'd20, 1'b1, 1'b0);
        @(negedge clk);
        chk("rst_pre_req", 32'(bus.wr_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_req", 32'(bus.wr_req), 32'd0);
        chk("rst_mid_addr", {10'd0, bus.wr_addr}, 32'd0);
        @(posedge clk); #1;
        rst        = 1'b0;
        bus.wr_ack = 1'b1;
        r0         = rx;
        idle(6);
        do_flush();
        idle(6);
        chk("rst_no_out", 32'(rx - r0), 32'd0);
        chk("rst_req_low", 32'(bus.wr_req), 32'd0);
        exp_q.push_back(mk(22'd280, 16'h00FF));
        for (int i = 0; i < 16; i++) tick(10'(i), 10'd7, i < 8, 1'b0);
        idle(5);
        chk("rst_next_word", 32'(rx - r0), 32'd1);

        // Flush on the same cycle as the last tick of a partial word.
        exp_q.push_back(mk(22'd40, 16'h00F0));
        r0 = rx;
        for (int x = 4; x < 7; x++) tick(10'(x), 10'd1, 1'b1, 1'b0);
        tick(10'd7, 10'd1, 1'b1, 1'b1);
        idle(6);
        chk("flush_tick_words", 32'(rx - r0), 32'd1);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("frame_done_total", 32'(fd), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
